// File: rtl/qbus_pkg.sv
// Shared widths, FSM state type and default reset value for the Qbus I/O-register slave.
package qbus_pkg;

  localparam int unsigned IOPAGE_AW = 13;
  localparam int unsigned DAL_W     = 22;
  localparam int unsigned DATA_W    = 16;

  localparam logic [DATA_W-1:0] DEFAULT_RESET_VALUE = 16'o123456;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSel,
    StRead,
    StWrite
  } state_e;

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer of parameterised width with asynchronous active-high reset.
module qbus_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/qbus_ioreg_slave.sv
// Qbus I/O-page slave with COUNT 16-bit registers; DATI, DATO and DATIO cycles.
// Optional byte writes (WTBT at DOUT) when QBUS_BYTE_WRITE_EN is defined.
module qbus_ioreg_slave
  import qbus_pkg::*;
#(
  parameter logic [IOPAGE_AW-1:0] ADDR        = 13'o17774,
  parameter int unsigned          COUNT       = 1,
  parameter logic [DATA_W-1:0]    RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DAL_W-1:0] dal_in,
  output logic [DAL_W-1:0] dal_out,
  output logic             dal_oe,
  input  logic             rsync,
  input  logic             rdin,
  input  logic             rdout,
  input  logic             rbs7,
  input  logic             rwtbt,
  input  logic             rinit,
  output logic             trply
);

  localparam int unsigned IW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned WA = IOPAGE_AW - 1;
  localparam logic [WA-1:0] BASE = ADDR[IOPAGE_AW-1:1];

  logic [5:0]       ctl_raw;
  logic [5:0]       ctl_s;
  logic [DAL_W-1:0] dal_s;
  logic s_sync, s_din, s_dout, s_bs7, s_wtbt, s_init;

  assign ctl_raw = {rsync, rdin, rdout, rbs7, rwtbt, rinit};

  qbus_sync #(.WIDTH(6)) u_ctl_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ctl_raw),
    .q     (ctl_s)
  );

  // Same depth as the control synchronizer so DAL stays aligned with SYNC/DIN/DOUT.
  qbus_sync #(.WIDTH(DAL_W)) u_dal_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (dal_in),
    .q     (dal_s)
  );

  assign {s_sync, s_din, s_dout, s_bs7, s_wtbt, s_init} = ctl_s;

  logic [WA-1:0] word;
  logic [WA-1:0] offset;
  logic          hit;

  assign word   = dal_s[IOPAGE_AW-1:1];
  assign offset = word - BASE;
  assign hit    = s_bs7 && (word >= BASE) && (32'(offset) < COUNT);

  state_e            state_q, state_d;
  logic              sync_prev_q;
  logic              hit_q, hit_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              bsel_q, bsel_d;
  logic              trply_q, trply_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] regs_q [COUNT];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (idx_q == IW'(i)) rd_word = regs_q[i];
    end
  end

`ifdef QBUS_BYTE_WRITE_EN
  always_comb begin
    wr_word = dal_s[DATA_W-1:0];
    if (s_wtbt) begin
      wr_word = bsel_q ? {dal_s[15:8], rd_word[7:0]} : {rd_word[15:8], dal_s[7:0]};
    end
  end

  logic unused_bits;
  assign unused_bits = ^dal_s[DAL_W-1:DATA_W];
`else
  assign wr_word = dal_s[DATA_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{dal_s[DAL_W-1:DATA_W], s_wtbt, bsel_q};
`endif

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    bsel_d  = bsel_q;
    trply_d = trply_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    if (!s_sync) begin
      state_d = StIdle;
      trply_d = 1'b0;
      oe_d    = 1'b0;
      dout_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!sync_prev_q) begin
            state_d = StAddr;
            hit_d   = hit;
            idx_d   = IW'(offset);
            bsel_d  = dal_s[0];
          end
        end
        // A miss parks here until SYNC negates.
        StAddr: if (hit_q) state_d = StSel;
        StSel: begin
          if (s_din) begin
            state_d = StRead;
            dout_d  = rd_word;
            oe_d    = 1'b1;
            trply_d = 1'b1;
          end else if (s_dout) begin
            state_d = StWrite;
            wr_en   = 1'b1;
            trply_d = 1'b1;
          end
        end
        StRead: begin
          if (!s_din) begin
            state_d = StSel;
            trply_d = 1'b0;
            oe_d    = 1'b0;
            dout_d  = '0;
          end
        end
        StWrite: begin
          if (!s_dout) begin
            state_d = StSel;
            trply_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sync_prev_q <= 1'b0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      bsel_q      <= 1'b0;
      trply_q     <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
    end else if (s_init) begin
      state_q     <= StIdle;
      sync_prev_q <= s_sync;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      bsel_q      <= 1'b0;
      trply_q     <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync_prev_q <= s_sync;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      bsel_q      <= bsel_d;
      trply_q     <= trply_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COUNT; i++) regs_q[i] <= RESET_VALUE;
    end else if (s_init) begin
      for (int i = 0; i < COUNT; i++) regs_q[i] <= RESET_VALUE;
    end else if (wr_en) begin
      for (int i = 0; i < COUNT; i++) begin
        if (idx_q == IW'(i)) regs_q[i] <= wr_word;
      end
    end
  end

  assign dal_out = {{(DAL_W - DATA_W){1'b0}}, dout_q};
  assign dal_oe  = oe_q;
  assign trply   = trply_q;

endmodule

// File: tb/tb_qbus_ioreg_slave.sv
// Bench: three slaves on one bus checked against a word-addressed memory model of the I/O page.
module tb_qbus_ioreg_slave;

  localparam logic [15:0] RV = 16'o123456;
  localparam logic [12:0] POOL [9] = '{13'o17774, 13'o17772, 13'o17740, 13'o17742, 13'o17744,
                                        13'o17746, 13'o17750, 13'o17770, 13'o17736};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [21:0] dal_in = '0;
  logic        rsync = 0, rdin = 0, rdout = 0, rbs7 = 0, rwtbt = 0, rinit = 0;
  logic [21:0] dout0, dout1, dout2;
  logic        oe0, oe1, oe2, tr0, tr1, tr2;
  logic [21:0] dal_out_bus;
  logic        oe_bus, trply_bus;

  assign dal_out_bus = dout0 | dout1 | dout2;
  assign oe_bus      = oe0 | oe1 | oe2;
  assign trply_bus   = tr0 | tr1 | tr2;

  always #5 clk = ~clk;

  qbus_ioreg_slave #(.ADDR(13'o17774), .COUNT(1), .RESET_VALUE(RV)) u0 (
    .clk(clk), .reset(reset), .dal_in(dal_in), .dal_out(dout0), .dal_oe(oe0), .rsync(rsync),
    .rdin(rdin), .rdout(rdout), .rbs7(rbs7), .rwtbt(rwtbt), .rinit(rinit), .trply(tr0)
  );
  qbus_ioreg_slave #(.ADDR(13'o17772), .COUNT(1), .RESET_VALUE(RV)) u1 (
    .clk(clk), .reset(reset), .dal_in(dal_in), .dal_out(dout1), .dal_oe(oe1), .rsync(rsync),
    .rdin(rdin), .rdout(rdout), .rbs7(rbs7), .rwtbt(rwtbt), .rinit(rinit), .trply(tr1)
  );
  qbus_ioreg_slave #(.ADDR(13'o17740), .COUNT(4), .RESET_VALUE(RV)) u2 (
    .clk(clk), .reset(reset), .dal_in(dal_in), .dal_out(dout2), .dal_oe(oe2), .rsync(rsync),
    .rdin(rdin), .rdout(rdout), .rbs7(rbs7), .rwtbt(rwtbt), .rinit(rinit), .trply(tr2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit saw_rply, saw_oe;

  logic [15:0] mem [4096];
  bit          mapped [4096];

  function automatic void model_reset();
    for (int i = 0; i < 4096; i++) mem[i] = RV;
  endfunction

  function automatic bit model_hit(input logic [21:0] a, input bit bs7);
    return bs7 && mapped[a[12:1]];
  endfunction

  task automatic model_write(input logic [21:0] a, input logic [15:0] d, input bit wtbt);
    int w;
    w = int'(a[12:1]);
`ifdef QBUS_BYTE_WRITE_EN
    if (wtbt) begin
      if (a[0]) mem[w][15:8] = d[15:8];
      else mem[w][7:0] = d[7:0];
    end else begin
      mem[w] = d;
    end
`else
    if (wtbt || !wtbt) mem[w] = d;
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    saw_rply |= trply_bus;
    saw_oe   |= oe_bus;
  endtask

  task automatic addr_phase(input logic [21:0] a, input bit bs7);
    dal_in = a;
    rbs7   = bs7;
    tick();
    rsync = 1'b1;
    repeat (3) tick();
    dal_in = 22'($urandom);
  endtask

  task automatic end_cycle();
    rsync  = 1'b0;
    rbs7   = 1'b0;
    dal_in = '0;
    repeat (4) tick();
  endtask

  task automatic data_read(output bit got, output int lat, output logic [21:0] data,
                           output bit oe, output bit rply_after, output bit oe_after);
    rdin = 1'b1;
    got = 0; lat = 0; data = '0; oe = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      tick();
      if (trply_bus) begin
        got = 1; lat = k; data = dal_out_bus; oe = oe_bus;
      end
    end
    rdin = 1'b0;
    repeat (4) tick();
    rply_after = trply_bus;
    oe_after   = oe_bus;
  endtask

  task automatic data_write(input logic [15:0] d, input bit wtbt, output bit got, output int lat,
                            output bit rply_after);
    dal_in = {6'($urandom), d};
    rwtbt  = wtbt;
    tick();
    rdout = 1'b1;
    got = 0; lat = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      tick();
      if (trply_bus) begin
        got = 1; lat = k;
      end
    end
    rdout = 1'b0;
    repeat (4) tick();
    rply_after = trply_bus;
    rwtbt = 1'b0;
  endtask

  // Full DATI with every check inline; used by the directed tests.
  task automatic dati_check(input string name, input logic [21:0] a, input bit bs7);
    bit got, oe, ra, oa; int lat; logic [21:0] d; bit exp_hit;
    exp_hit = model_hit(a, bs7);
    saw_rply = 0; saw_oe = 0;
    addr_phase(a, bs7);
    data_read(got, lat, d, oe, ra, oa);
    end_cycle();
    n_cmp++;
    if (got !== exp_hit) begin
      n_bad++; $display("FAIL %s reply: got %0b want %0b", name, got, exp_hit);
    end
    if (exp_hit) begin
      n_cmp += 4;
      if (d !== {6'b0, mem[a[12:1]]}) begin
        n_bad++; $display("FAIL %s data: got %o want %o", name, d, mem[a[12:1]]);
      end
      if (oe !== 1'b1) begin
        n_bad++; $display("FAIL %s oe at reply: got %0b want 1", name, oe);
      end
      if (lat > 4) begin
        n_bad++; $display("FAIL %s latency: got %0d want <=4", name, lat);
      end
      if ({ra, oa} !== 2'b00) begin
        n_bad++; $display("FAIL %s release: rply/oe got %b want 00", name, {ra, oa});
      end
    end else begin
      n_cmp++;
      if ({saw_rply, saw_oe} !== 2'b00) begin
        n_bad++; $display("FAIL %s nxm quiet: rply/oe seen %b want 00", name, {saw_rply, saw_oe});
      end
    end
    n_cmp++;
    if ({trply_bus, oe_bus} !== 2'b00) begin
      n_bad++; $display("FAIL %s idle: rply/oe got %b want 00", name, {trply_bus, oe_bus});
    end
  endtask

  task automatic dato_check(input string name, input logic [21:0] a, input logic [15:0] d,
                            input bit wtbt);
    bit got, ra; int lat;
    addr_phase(a, 1'b1);
    data_write(d, wtbt, got, lat, ra);
    end_cycle();
    if (model_hit(a, 1'b1)) model_write(a, d, wtbt);
    n_cmp++;
    if (got !== model_hit(a, 1'b1) || (got && (lat > 4 || ra))) begin
      n_bad++; $display("FAIL %s write reply: got %0b lat %0d after %0b want %0b", name, got,
                        lat, ra, model_hit(a, 1'b1));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp += 3;
    if (trply_bus !== 1'b0) begin n_bad++; $display("FAIL reset trply: got %b want 0", trply_bus); end
    if (oe_bus !== 1'b0) begin n_bad++; $display("FAIL reset dal_oe: got %b want 0", oe_bus); end
    if (dal_out_bus !== '0) begin n_bad++; $display("FAIL reset dal_out: got %o want 0", dal_out_bus); end
    reset = 1'b0;
    model_reset();
    repeat (2) tick();
  endtask

  task automatic test_dati();
    dati_check("dati_17777774", 22'o17777774, 1'b1);
    dati_check("dati_17774_upper0", 22'o00017774, 1'b1);
    dati_check("dati_odd_byte_addr", 22'o00017775, 1'b1);
  endtask

  task automatic test_nxm();
    dati_check("nxm_17777770", 22'o17777770, 1'b1);
    dati_check("nxm_no_bs7", 22'o17777774, 1'b0);
    dati_check("nxm_above_window", 22'o17750, 1'b1);
    dati_check("nxm_below_window", 22'o17736, 1'b1);
  endtask

  task automatic test_dato();
    dato_check("dato_17777774", 22'o17777774, 16'o054321, 1'b0);
    dati_check("dato_readback", 22'o17777774, 1'b1);
    n_cmp++;
    if (mem[13'o17774 >> 1] !== 16'o054321) begin
      n_bad++; $display("FAIL dato model: got %o want 054321", mem[13'o17774 >> 1]);
    end
    dati_check("dato_other_instance", 22'o17772, 1'b1);
    dato_check("dato_window_top", 22'o17746, 16'o111222, 1'b0);
    dati_check("dato_window_top_rb", 22'o17746, 1'b1);
    dati_check("dato_window_bottom", 22'o17740, 1'b1);
  endtask

  task automatic test_datio();
    bit got, oe, ra, oa, wgot, wra; int lat, wlat; logic [21:0] d;
    addr_phase(22'o17772, 1'b1);
    data_read(got, lat, d, oe, ra, oa);
    data_write(16'o54545, 1'b0, wgot, wlat, wra);
    end_cycle();
    model_write(22'o17772, 16'o54545, 1'b0);
    n_cmp += 2;
    if (!got || d !== {6'b0, RV}) begin
      n_bad++; $display("FAIL datio read: reply %0b data %o want 1 %o", got, d, RV);
    end
    if (!wgot || wlat > 4 || wra) begin
      n_bad++; $display("FAIL datio write: reply %0b lat %0d after %0b want 1 <=4 0", wgot, wlat, wra);
    end
    dati_check("datio_readback", 22'o17772, 1'b1);
  endtask

  task automatic test_rd_wr_collide();
    bit got; logic [21:0] d;
    addr_phase(22'o17742, 1'b1);
    dal_in = 22'o0001234;
    rdin = 1'b1; rdout = 1'b1;
    got = 0; d = '0;
    for (int k = 1; k <= 8 && !got; k++) begin
      tick();
      if (trply_bus) begin got = 1; d = dal_out_bus; end
    end
    rdin = 1'b0; rdout = 1'b0;
    repeat (4) tick();
    end_cycle();
    n_cmp++;
    if (!got || d !== {6'b0, mem[13'o17742 >> 1]}) begin
      n_bad++; $display("FAIL collide read: reply %0b data %o want 1 %o", got, d, mem[13'o17742 >> 1]);
    end
    dati_check("collide_no_write", 22'o17742, 1'b1);
  endtask

  task automatic test_init();
    dato_check("init_pre_write", 22'o17744, 16'o000777, 1'b0);
    rinit = 1'b1;
    repeat (4) tick();
    rinit = 1'b0;
    repeat (3) tick();
    model_reset();
    dati_check("init_restores", 22'o17744, 1'b1);
  endtask

  task automatic test_mid_read_reset();
    bit got;
    addr_phase(22'o17774, 1'b1);
    rdin = 1'b1;
    got = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      tick();
      if (trply_bus && oe_bus) got = 1;
    end
    reset = 1'b1;
    #1;
    n_cmp += 2;
    if (!got) begin n_bad++; $display("FAIL midreset setup: reply got 0 want 1"); end
    if ({trply_bus, oe_bus} !== 2'b00) begin
      n_bad++; $display("FAIL midreset drop: rply/oe got %b want 00", {trply_bus, oe_bus});
    end
    rdin = 1'b0; rsync = 1'b0; rbs7 = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    repeat (2) tick();
    dati_check("midreset_reg0", 22'o17774, 1'b1);
    dati_check("midreset_reg_other", 22'o17746, 1'b1);
  endtask

  task automatic test_byte_write();
    dato_check("byte_write", 22'o17775, 16'o177400, 1'b1);
    n_cmp++;
`ifdef QBUS_BYTE_WRITE_EN
    if (mem[13'o17774 >> 1] !== 16'o177456) begin
      n_bad++; $display("FAIL byte model: got %o want 177456", mem[13'o17774 >> 1]);
    end
`else
    if (mem[13'o17774 >> 1] !== 16'o177400) begin
      n_bad++; $display("FAIL word model: got %o want 177400", mem[13'o17774 >> 1]);
    end
`endif
    dati_check("byte_write_rb", 22'o17774, 1'b1);
    dato_check("byte_write_low", 22'o17740, 16'o000252, 1'b1);
    dati_check("byte_write_low_rb", 22'o17740, 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [21:0] a; bit bs7; int op;
      a = 22'($urandom);
      a[12:1] = POOL[$urandom_range(0, 8)][12:1];
      bs7 = ($urandom_range(0, 9) != 0);
      op = $urandom_range(0, 2);
      if (op == 0 || !bs7) begin
        dati_check("rand_dati", a, bs7);
      end else if (op == 1) begin
        dato_check("rand_dato", a, 16'($urandom), 1'($urandom));
        dati_check("rand_dato_rb", a, 1'b1);
      end else begin
        bit got, oe, ra, oa, wgot, wra; int lat, wlat; logic [21:0] d; logic [15:0] wd;
        bit wt; bit exp_hit;
        wd = 16'($urandom); wt = 1'($urandom);
        exp_hit = model_hit(a, 1'b1);
        addr_phase(a, 1'b1);
        data_read(got, lat, d, oe, ra, oa);
        data_write(wd, wt, wgot, wlat, wra);
        end_cycle();
        n_cmp += 2;
        if (got !== exp_hit || (exp_hit && d !== {6'b0, mem[a[12:1]]})) begin
          n_bad++; $display("FAIL rand_datio read: reply %0b data %o want %0b %o", got, d,
                            exp_hit, mem[a[12:1]]);
        end
        if (wgot !== exp_hit) begin
          n_bad++; $display("FAIL rand_datio write: reply %0b want %0b", wgot, exp_hit);
        end
        if (exp_hit) model_write(a, wd, wt);
        dati_check("rand_datio_rb", a, 1'b1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mapped[i] = 0;
    mapped[13'o17774 >> 1] = 1;
    mapped[13'o17772 >> 1] = 1;
    for (int i = 0; i < 4; i++) mapped[(13'o17740 >> 1) + i] = 1;
    model_reset();
    test_reset();
    test_dati();
    test_nxm();
    test_dato();
    test_datio();
    test_rd_wr_collide();
    test_init();
    test_mid_read_reset();
    test_byte_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qbus_ioreg_slave.md
Name: qbus_ioreg_slave

Overview:
- Synchronous Qbus I/O-page slave: a bank of COUNT 16-bit registers at a configurable I/O-page word address.
- Supports DATI (read), DATO (write) and DATIO (read-modify-write); does not reply to addresses outside its window (master times out, NXM).
- Sits behind the open-collector transceiver layer: all bus signals here are true-sense (1 = asserted).
- DAL is split into in, out and output-enable.

Parameters:
- ADDR, 'o17774, 13-bit I/O-page byte address of register 0 (even).
- COUNT, 1, number of consecutive 16-bit registers, 1..16.
- RESET_VALUE, 'o123456, value loaded into every register on reset/init.

Ports:
- clk  in  1  system clock, ≥50 MHz required.
- reset  in  1  asynchronous, active-high.
- dal_in  in  22  DAL as received from bus.
- dal_out  out  22  DAL drive data; bits 21:16 always 0.
- dal_oe  out  1  enables DAL transmitters; wire-ORed with other slaves.
- rsync  in  1  SYNC received.
- rdin  in  1  DIN received.
- rdout  in  1  DOUT received.
- rbs7  in  1  BS7 (I/O page) received.
- rwtbt  in  1  WTBT received.
- rinit  in  1  bus INIT.
- trply  out  1  RPLY transmit; wire-ORed.

Behaviour:
- Reset/rinit: all registers = RESET_VALUE; trply=0, dal_oe=0, dal_out=0, state IDLE. Reset is async; rinit is sampled after synchronization.
- Synchronization:
  - rsync, rdin, rdout, rbs7, rwtbt, rinit each pass through a 2-flop synchronizer.
  - dal_in passes through an equal-depth register pipeline so data stays aligned with the control signals.
- FSM states: IDLE, ADDR, SEL, READ, WRITE.
- IDLE→ADDR on synchronized rising edge of rsync.
- Address decode, evaluated at that edge using the aligned DAL and BS7:
  - Hit when bs7=1 and DAL[12:1] is in [ADDR[12:1], ADDR[12:1]+COUNT-1].
  - DAL[21:13] is ignored, so 'o17777774 and 'o17774 are equivalent.
  - DAL[0] is ignored for word access.
  - Miss → stay non-selected until rsync negates; never assert trply or dal_oe.
  - Hit → SEL, latching the word index.
- SEL + rdin=1 → READ:
  - dal_out[15:0] = reg[index]; dal_oe=1.
  - trply=1 on the same or following clock, never before data is valid.
  - Max latency from raw rdin assertion to trply: 4 clk.
- READ + rdin=0 → trply=0, dal_oe=0 on next clk; return to SEL.
- SEL + rdout=1 → WRITE:
  - Capture aligned DAL[15:0] into reg[index] once; trply=1. Max latency 4 clk.
- WRITE + rdout=0 → trply=0; return to SEL.
- DATIO: a read then a write within one SYNC is supported through SEL; WTBT during the address phase is not required.
- rsync negation in any state → IDLE; trply=0, dal_oe=0.
- A write at the same clk as a read of the same register: the read returns the old value.
- Simultaneous rdin and rdout (illegal): rdin wins; no write.
- Reset asserted mid-cycle: outputs drop immediately (async).

Optional Feature:
- Macro QBUS_BYTE_WRITE_EN.
- When defined: rwtbt=1 sampled at the DOUT edge selects a byte write.
  - Address bit 0 latched at ADDR selects the byte: 0 = [7:0] from DAL[7:0], 1 = [15:8] from DAL[15:8].
  - The other byte is unchanged.
- When undefined: rwtbt is ignored during data; every write is a full 16-bit word.

Decomposition:
- Package qbus_pkg:
  - IOPAGE_AW=13, DAL_W=22, DATA_W=16.
  - FSM state enum.
  - Default RESET_VALUE constant.
- One sub-module, qbus_sync: parameterized-width 2-flop synchronizer with async reset; used for control signals and the DAL pipeline.

Test Plan:
- Reset, then DATI 'o17777774 (ADDR='o17774) → trply within 4 clk of rdin, dal_out[15:0]='o123456, dal_oe=1; both drop after rdin/rsync negate.
- DATI 'o17777770 → trply and dal_oe stay 0 for the whole cycle (NXM).
- DATI 'o17774 with upper DAL bits 0 → returns 'o123456 (upper bits ignored).
- DATO 'o17777774 data 'o054321, then DATI → 'o054321. A second instance at 'o17772 still returns 'o123456.
- DATIO at 'o17772: read → 'o123456; then DAL='o54545 with DOUT in the same SYNC → trply pulse; a subsequent DATI returns 'o54545.
- Mid-read reset: trply and dal_oe drop immediately; registers return to 'o123456. With QBUS_BYTE_WRITE_EN, byte write to address 'o17775 with data 'o177400 → register 'o177456.
